vote_link_arbiter: RTL and testbench

VOTE_LINK_ARBITER -- requirements
Module: vote_link_arbiter

---
 rtl/vote_link_arbiter.sv | 117 +++++++++++
 tb/tb_vote_link_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_link_arbiter.sv
// Round-robin arbiter that forwards one 4-bit station vote at a time to a central tally link.
// Votes with bad parity, or votes the tally does not accept within TIMEOUT cycles, are rejected and counted.
module vote_link_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [15:0] v_in,
   output logic [3:0]  gnt,
   output logic [3:0]  ack,
   output logic [3:0]  nack,
   output logic        link_rtr,
   input  logic        link_cts,
   output logic [3:0]  link_v_out,
   output logic [1:0]  link_id,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CHECK, SEND, RELEASE} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state;
   logic [1:0]  ptr;
   logic [1:0]  w;
   logic [3:0]  vote_q;
   logic [7:0]  tcnt;
   logic [1:0]  win;
   logic [1:0]  idx;

   // Round-robin pick: scanning downward lets the closest set bit after ptr overwrite the others.
   always_comb begin
      win = ptr;
      idx = '0;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) win = idx;
      end
   end

   // Single registered FSM; ack/nack default low so they only ever pulse for one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= 2'd3;
         w          <= '0;
         vote_q     <= '0;
         tcnt       <= '0;
         gnt        <= '0;
         ack        <= '0;
         nack       <= '0;
         link_rtr   <= 1'b0;
         link_v_out <= '0;
         link_id    <= '0;
         err_cnt    <= '0;
         busy       <= 1'b0;
      end else begin
         ack  <= '0;
         nack <= '0;
         case (state)
            IDLE: begin
               if (req != 4'b0000) begin
                  w      <= win;
                  vote_q <= v_in[{win, 2'b00} +: 4];
                  gnt    <= 4'b0001 << win;
                  busy   <= 1'b1;
                  state  <= CHECK;
               end else begin
                  gnt  <= '0;
                  busy <= 1'b0;
               end
            end
            CHECK: begin
               if (vote_q[3] == ^vote_q[2:0]) begin
                  link_rtr   <= 1'b1;
                  link_v_out <= vote_q;
                  link_id    <= w;
                  tcnt       <= '0;
                  state      <= SEND;
               end else begin
                  nack[w] <= 1'b1;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  state   <= RELEASE;
               end
            end
            SEND: begin
               // Acceptance is tested first so a link_cts in the final cycle still counts as delivered.
               if (link_cts) begin
                  ack[w]   <= 1'b1;
                  link_rtr <= 1'b0;
                  state    <= RELEASE;
               end else begin
                  tcnt <= tcnt + 8'd1;
                  if (tcnt + 8'd1 == TMO) begin
                     nack[w]  <= 1'b1;
                     link_rtr <= 1'b0;
                     if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                     state    <= RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (!req[w] && !link_cts) begin
                  gnt   <= '0;
                  ptr   <= w;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vote_link_arbiter.sv
// Randomized bench for vote_link_arbiter, checked against a transaction-level model of the arbitration rules.
module tb_vote_link_arbiter;

   localparam int TMO = 15;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] v_in;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [3:0]  nack;
   logic        link_rtr;
   logic        link_cts;
   logic [3:0]  link_v_out;
   logic [1:0]  link_id;
   logic [7:0]  err_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 3;
   int m_err  = 0;

   vote_link_arbiter #(.TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .req(req), .v_in(v_in), .gnt(gnt), .ack(ack), .nack(nack),
      .link_rtr(link_rtr), .link_cts(link_cts), .link_v_out(link_v_out), .link_id(link_id),
      .err_cnt(err_cnt), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int rr_pick(int p, logic [3:0] r);
      for (int k = 1; k <= 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic int sat_err(int e);
      return (e > 255) ? 255 : e;
   endfunction

   // Serves whichever station gets granted next; only observes, the test tasks judge the result.
   task automatic serve_one(input int cts_delay, output logic [3:0] g, output logic [3:0] a,
                            output logic [3:0] n, output int rtr_n, output logic [3:0] vout,
                            output logic [1:0] id, output bit hung);
      int cyc;
      bit done;
      g = '0; a = '0; n = '0; rtr_n = 0; vout = '0; id = '0; hung = 0; done = 0;
      cyc = 0;
      while (gnt == 4'b0000 && cyc < 20) begin @(negedge clock); cyc++; end
      if (gnt == 4'b0000) begin hung = 1; return; end
      g = gnt;
      cyc = 0;
      while (!done && cyc < 300) begin
         if (link_rtr) begin
            rtr_n++;
            vout = link_v_out;
            id   = link_id;
            if (cts_delay >= 0 && rtr_n > cts_delay) link_cts = 1'b1;
         end
         @(negedge clock);
         cyc++;
         a |= ack;
         n |= nack;
         if (ack != 4'b0000 || nack != 4'b0000) begin
            done = 1;
            link_cts = 1'b0;
            req &= ~g;
         end
      end
      if (!done) begin hung = 1; link_cts = 1'b0; return; end
      cyc = 0;
      while (gnt != 4'b0000 && cyc < 20) begin @(negedge clock); cyc++; end
      if (gnt != 4'b0000) hung = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; v_in = '0; link_cts = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if ((ack | nack) !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack_nack: got %b/%b expected 0000/0000", ack, nack); end
      checks++; if (link_rtr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rtr: got %b expected 0", link_rtr); end
      checks++; if ({link_v_out, link_id} !== 6'd0) begin errors++; $display("[TB] FAIL reset_link: got %h/%0d expected 0/0", link_v_out, link_id); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err: got %0d expected 0", err_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      m_ptr = 3; m_err = 0;
      repeat (3) @(negedge clock);
      checks++; if ({gnt, busy} !== 5'd0) begin errors++; $display("[TB] FAIL idle_no_req: got gnt %b busy %b expected 0000 0", gnt, busy); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] g, a, n, vout;
      logic [1:0] id;
      int rtr_n, w;
      bit hung;
      v_in = 16'h0000;
      req  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         w = rr_pick(m_ptr, req);
         serve_one(1, g, a, n, rtr_n, vout, id, hung);
         checks++; if (hung || g !== 4'(1 << w) || w != k) begin errors++; $display("[TB] FAIL b2b_order%0d: got gnt %b hung %0d expected %b", k, g, hung, 4'(1 << k)); end
         checks++; if (a !== g || n !== 4'b0000 || rtr_n != 2) begin errors++; $display("[TB] FAIL b2b_ack%0d: got ack %b nack %b rtr %0d expected %b 0000 2", k, a, n, rtr_n, g); end
         m_ptr = w;
      end
   endtask

   task automatic test_basic();
      logic [3:0] g, a, n, vout;
      logic [1:0] id;
      int rtr_n;
      bit hung;
      v_in = 16'h0006;
      req  = 4'b0001;
      serve_one(3, g, a, n, rtr_n, vout, id, hung);
      checks++; if (hung || g !== 4'b0001) begin errors++; $display("[TB] FAIL basic_gnt: got %b hung %0d expected 0001", g, hung); end
      checks++; if (vout !== 4'b0110 || id !== 2'd0) begin errors++; $display("[TB] FAIL basic_link: got %b/%0d expected 0110/0", vout, id); end
      checks++; if (a !== 4'b0001 || n !== 4'b0000 || rtr_n != 4) begin errors++; $display("[TB] FAIL basic_ack: got %b/%b rtr %0d expected 0001/0000 4", a, n, rtr_n); end
      checks++; if (err_cnt !== 8'(sat_err(m_err))) begin errors++; $display("[TB] FAIL basic_err: got %0d expected %0d", err_cnt, sat_err(m_err)); end
      m_ptr = 0;
   endtask

   task automatic test_parity_error();
      logic [3:0] g, a, n, vout;
      logic [1:0] id;
      int rtr_n;
      bit hung;
      v_in = 16'h0700;
      req  = 4'b0100;
      serve_one(0, g, a, n, rtr_n, vout, id, hung);
      m_err++; m_ptr = 2;
      checks++; if (hung || g !== 4'b0100) begin errors++; $display("[TB] FAIL parity_gnt: got %b hung %0d expected 0100", g, hung); end
      checks++; if (n !== 4'b0100 || a !== 4'b0000 || rtr_n != 0) begin errors++; $display("[TB] FAIL parity_nack: got nack %b ack %b rtr %0d expected 0100 0000 0", n, a, rtr_n); end
      checks++; if (err_cnt !== 8'(sat_err(m_err))) begin errors++; $display("[TB] FAIL parity_err: got %0d expected %0d", err_cnt, sat_err(m_err)); end
   endtask

   task automatic test_timeout();
      logic [3:0] g, a, n, vout;
      logic [1:0] id;
      int rtr_n;
      bit hung;
      v_in = 16'h0030;
      req  = 4'b0010;
      serve_one(-1, g, a, n, rtr_n, vout, id, hung);
      m_err++; m_ptr = 1;
      checks++; if (hung || rtr_n != TMO || n !== 4'b0010 || a !== 4'b0000) begin errors++; $display("[TB] FAIL timeout_nack: got rtr %0d nack %b ack %b hung %0d expected %0d 0010 0000", rtr_n, n, a, hung, TMO); end
      checks++; if (err_cnt !== 8'(sat_err(m_err))) begin errors++; $display("[TB] FAIL timeout_err: got %0d expected %0d", err_cnt, sat_err(m_err)); end
      req = 4'b0010;
      serve_one(TMO - 1, g, a, n, rtr_n, vout, id, hung);
      checks++; if (hung || rtr_n != TMO || a !== 4'b0010 || n !== 4'b0000) begin errors++; $display("[TB] FAIL timeout_last_cts: got rtr %0d ack %b nack %b expected %0d 0010 0000", rtr_n, a, n, TMO); end
      checks++; if (err_cnt !== 8'(sat_err(m_err))) begin errors++; $display("[TB] FAIL timeout_last_err: got %0d expected %0d", err_cnt, sat_err(m_err)); end
   endtask

   task automatic test_random();
      logic [3:0] g, a, n, vout, nib, exp_a, exp_n;
      logic [1:0] id;
      int rtr_n, w, delay, exp_rtr;
      bit hung, good;
      req = '0;
      for (int t = 0; t < 60 && (t < 24 || req != 4'b0000); t++) begin
         if (t < 24) begin
            req |= 4'($urandom_range(0, 15));
            if (req == 4'b0000) req = 4'(1 << $urandom_range(0, 3));
         end
         v_in  = 16'($urandom);
         delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
         w     = rr_pick(m_ptr, req);
         nib   = v_in[4*w +: 4];
         good  = ($countones(nib) % 2) == 0;
         exp_a = '0; exp_n = '0;
         if (!good) begin exp_n = 4'(1 << w); exp_rtr = 0; m_err++; end
         else if (delay < 0) begin exp_n = 4'(1 << w); exp_rtr = TMO; m_err++; end
         else begin exp_a = 4'(1 << w); exp_rtr = delay + 1; end
         serve_one(delay, g, a, n, rtr_n, vout, id, hung);
         checks++; if (hung || g !== 4'(1 << w)) begin errors++; $display("[TB] FAIL rand_gnt%0d: got %b hung %0d expected %b", t, g, hung, 4'(1 << w)); end
         checks++; if (a !== exp_a || n !== exp_n || rtr_n != exp_rtr) begin errors++; $display("[TB] FAIL rand_result%0d: got ack %b nack %b rtr %0d expected %b %b %0d", t, a, n, rtr_n, exp_a, exp_n, exp_rtr); end
         checks++; if (good && (vout !== nib || id !== 2'(w))) begin errors++; $display("[TB] FAIL rand_link%0d: got %b/%0d expected %b/%0d", t, vout, id, nib, w); end
         checks++; if (err_cnt !== 8'(sat_err(m_err))) begin errors++; $display("[TB] FAIL rand_err%0d: got %0d expected %0d", t, err_cnt, sat_err(m_err)); end
         m_ptr = w;
      end
   endtask

   task automatic test_reset_mid_send();
      logic [3:0] g, a, n, vout;
      logic [1:0] id;
      int rtr_n, cyc;
      bit hung;
      v_in = 16'h9006;
      req  = 4'b0001;
      cyc  = 0;
      while (!link_rtr && cyc < 20) begin @(negedge clock); cyc++; end
      checks++; if (link_rtr !== 1'b1) begin errors++; $display("[TB] FAIL midsend_reach: got rtr %b expected 1", link_rtr); end
      reset = 1'b1;
      @(negedge clock);
      checks++; if ({gnt, link_rtr, busy} !== 6'd0) begin errors++; $display("[TB] FAIL midsend_abort: got gnt %b rtr %b busy %b expected 0000 0 0", gnt, link_rtr, busy); end
      checks++; if ((ack | nack) !== 4'b0000 || err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midsend_pulse: got ack %b nack %b err %0d expected 0000 0000 0", ack, nack, err_cnt); end
      req   = 4'b1001;
      reset = 1'b0;
      m_ptr = 3; m_err = 0;
      serve_one(0, g, a, n, rtr_n, vout, id, hung);
      checks++; if (hung || g !== 4'b0001 || a !== 4'b0001) begin errors++; $display("[TB] FAIL midsend_first: got gnt %b ack %b expected 0001 0001", g, a); end
      serve_one(0, g, a, n, rtr_n, vout, id, hung);
      checks++; if (hung || g !== 4'b1000 || a !== 4'b1000) begin errors++; $display("[TB] FAIL midsend_second: got gnt %b ack %b expected 1000 1000", g, a); end
      m_ptr = 3;
   endtask

   task automatic test_err_saturation();
      logic [3:0] g, a, n, vout;
      logic [1:0] id;
      int rtr_n;
      bit hung;
      v_in = 16'h0007;
      for (int t = 0; t < 260; t++) begin
         req = 4'b0001;
         serve_one(0, g, a, n, rtr_n, vout, id, hung);
         m_err++;
         checks++; if (hung || n !== 4'b0001 || err_cnt !== 8'(sat_err(m_err))) begin errors++; $display("[TB] FAIL sat_err%0d: got nack %b err %0d expected 0001 %0d", t, n, err_cnt, sat_err(m_err)); end
      end
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_final: got %0d expected 255", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_basic();
      test_parity_error();
      test_timeout();
      test_random();
      test_reset_mid_send();
      test_err_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
